rggen_axi4lite_register_slice: RTL and testbench
================================================

Name: rggen_axi4lite_register_slice

Overview:
- Per-channel AXI4-Lite pipeline slice placed directly upstream of the AXI4-Lite bus adapter. Sits between the interconnect-side master and the adapter slave port.
- Breaks every combinational valid/ready/payload path between the two sides (AW, W, AR, B, R), e.g. the adapter's awready-depends-on-wvalid path.
- Sustains one transfer per cycle per channel with 1 cycle of added latency per direction.

Parameters:
- ADDRESS_WIDTH, 8, width of awaddr/araddr.
- BUS_WIDTH, 32, width of wdata/rdata; wstrb is BUS_WIDTH/8.
- CHANNEL_SLICE, 5'b11111, per-channel enable, bit order {R,B,AR,W,AW}. 1 = skid buffer; 0 = pure wire pass-through for that channel.

Ports:
- i_clk  input  1  clock; all flops on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- s_axi4lite_if  rggen_axi4lite_if.slave  -  upstream side, facing the interconnect master.
- m_axi4lite_if  rggen_axi4lite_if.master  -  downstream side, facing the adapter slave port.

Behaviour:
- Interface and reset: one clock; reset is synchronous and active-high. Both are fixed.
- Channel direction: AW, W and AR flow s->m; B and R flow m->s.
- Payload per channel is every non-handshake field of that channel:
  - AW: awaddr, awprot
  - W: wdata, wstrb
  - AR: araddr, arprot
  - B: bresp
  - R: rdata, rresp
- Each enabled channel is one skid-buffer instance with an output register (OUT) and a skid register (SKID).
- States:
  - EMPTY: no entries held.
  - BUSY: OUT valid.
  - FULL: OUT and SKID valid.
- Outputs are driven only from flops:
  - out_valid = (state != EMPTY)
  - out_payload = OUT
  - in_ready = registered flag that is 1 when the next state is not FULL.
- Transitions (in_acc = in_valid & in_ready; out_acc = out_valid & out_ready):
  - EMPTY: in_acc -> BUSY, OUT <= in.
  - BUSY, in_acc & out_acc: stay BUSY, OUT <= in.
  - BUSY, in_acc only: -> FULL, SKID <= in.
  - BUSY, out_acc only: -> EMPTY.
  - FULL: out_acc -> BUSY, OUT <= SKID. in_ready is 0, so there is no input accept.
- Latency: a beat accepted in cycle N is presented at the output in cycle N+1.
- Throughput: full rate whenever out_ready is held at 1.
- Ordering: strict FIFO per channel. A beat is never dropped, duplicated or reordered.
- Simultaneous accept on both sides: handled as listed above. BUSY never passes through EMPTY.
- AXI rule: once out_valid is asserted, the payload is stable until out_acc.
- Channels are independent:
  - No AW/W pairing is done here; the adapter pairs them.
  - AR and AW may advance in the same cycle.
- Reset, including in the middle of a transfer:
  - Next cycle: every state = EMPTY, all valid outputs = 0, all in_ready = 0.
  - in_ready rises to 1 on the first cycle after i_rst deasserts.
  - Buffered beats are discarded.
  - Payload flops are not reset; their contents are don't-care while valid = 0.
- CHANNEL_SLICE bit = 0: valid, ready and payload are assign-connected, with zero latency and no flops.
- Width rules: payload width per channel is derived from the parameters. The module has no arithmetic.

Decomposition:
- rggen_rtl_pkg holds:
  - rggen_skid_buffer_state enum {EMPTY, BUSY, FULL}, 2 bits.
  - Helper constants for the channel index order (AW=0, W=1, AR=2, B=3, R=4).
- One generic sub-module, rggen_skid_buffer:
  - Parameters: WIDTH, ENABLE.
  - Ports: i_clk, i_rst, i_valid, o_ready, i_data, o_valid, i_ready, o_data.
  - Instantiated five times from rggen_axi4lite_register_slice.
  - Payload fields are concatenated and split in the top level.

Test Plan:
- Reset then idle: assert i_rst for 3 cycles with awvalid=1 -> all valid=0 and all ready=0 during reset; s.awready=1 on the first cycle after release; m.awvalid=1 one cycle after the first accept.
- Back-to-back writes with m ready tied to 1: AW addr 0x10,0x14,0x18 with W data 0xA5A5A5A5,0x1,0x2 and wstrb 4'hF -> m side sees the same 3 beats in order, 1 cycle later, with no bubble.
- Backpressure: m.arready=0; send araddr 0x20 then 0x24 -> s.arready drops to 0 after the 2nd accept (FULL); release ready -> 0x20 then 0x24 emerge on consecutive cycles, and 0x24 is stable while stalled.
- Response path: downstream returns rvalid with rdata 0xDEADBEEF, rresp 2'b10 while s.rready=0 for 4 cycles -> s.rvalid held at 1 with constant payload; a single beat transfers when rready=1.
- Simultaneous in/out accept in BUSY: alternate s.bready 1/0 while bresp 2'b00/2'b01 streams in -> no loss and no duplication; the scoreboard matches 16 responses.
- Reset during FULL: fill the AW channel (2 beats held), assert i_rst 1 cycle -> m.awvalid=0 next cycle; after release the first m.awaddr seen is a new beat 0x40, not a stale one. Also run CHANNEL_SLICE=5'b00000 -> zero-latency pass-through equivalence.

Source files
------------

// File: rtl/rggen_axi4lite_register_slice_pkg.sv
// ---------------------------------------------------------------------------
// rggen_rtl_pkg
// Shared types and constants for the AXI4-Lite register slice.
//   rggen_skid_buffer_state : occupancy of one skid-buffer channel
//   RGGEN_CH_*              : bit index of each channel in CHANNEL_SLICE
//   RGGEN_AXI_*_W           : fixed AXI4-Lite sideband widths
// ---------------------------------------------------------------------------
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } rggen_skid_buffer_state;

  localparam int RGGEN_CH_AW = 0;
  localparam int RGGEN_CH_W  = 1;
  localparam int RGGEN_CH_AR = 2;
  localparam int RGGEN_CH_B  = 3;
  localparam int RGGEN_CH_R  = 4;

  localparam int RGGEN_AXI_PROT_W = 3;
  localparam int RGGEN_AXI_RESP_W = 2;

endpackage

// File: rtl/rggen_axi4lite_register_slice_if.sv
// ---------------------------------------------------------------------------
// rggen_axi4lite_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   master modport : drives AW/W/AR valid+payload and B/R ready
//   slave  modport : drives AW/W/AR ready and B/R valid+payload
// ---------------------------------------------------------------------------
interface rggen_axi4lite_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                     awvalid;
  logic                     awready;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0]               awprot;
  logic                     wvalid;
  logic                     wready;
  logic [BUS_WIDTH-1:0]     wdata;
  logic [BUS_WIDTH/8-1:0]   wstrb;
  logic                     bvalid;
  logic                     bready;
  logic [1:0]               bresp;
  logic                     arvalid;
  logic                     arready;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [2:0]               arprot;
  logic                     rvalid;
  logic                     rready;
  logic [BUS_WIDTH-1:0]     rdata;
  logic [1:0]               rresp;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rdata, rresp, output rready
  );

  modport slave (
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );
endinterface

// File: rtl/rggen_axi4lite_register_slice_skid_buffer.sv
// ---------------------------------------------------------------------------
// rggen_skid_buffer
// Two-entry valid/ready skid buffer; all outputs come straight from flops.
// With ENABLE = 0 it collapses to wires (zero latency, no state).
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_valid/o_ready/i_data : upstream handshake and payload
//   o_valid/i_ready/o_data : downstream handshake and payload
// ---------------------------------------------------------------------------
module rggen_skid_buffer
  import rggen_rtl_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter bit ENABLE = 1'b1
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);
  generate
    if (ENABLE) begin : g_slice
      rggen_skid_buffer_state r_state;
      rggen_skid_buffer_state w_state_next;
      logic                   r_ready;
      logic [WIDTH-1:0]       r_out;
      logic [WIDTH-1:0]       r_skid;
      logic                   w_in_acc;
      logic                   w_out_acc;
      logic                   w_load_out_in;
      logic                   w_load_out_skid;
      logic                   w_load_skid;

      assign w_in_acc  = i_valid & r_ready;
      assign w_out_acc = (r_state != EMPTY) & i_ready;

      always_comb begin
        w_state_next    = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
          EMPTY: begin
            if (w_in_acc) begin
              w_state_next  = BUSY;
              w_load_out_in = 1'b1;
            end
          end
          BUSY: begin
            // Simultaneous accept refills OUT directly, never via EMPTY.
            if (w_in_acc && w_out_acc) begin
              w_load_out_in = 1'b1;
            end else if (w_in_acc) begin
              w_state_next = FULL;
              w_load_skid  = 1'b1;
            end else if (w_out_acc) begin
              w_state_next = EMPTY;
            end
          end
          FULL: begin
            if (w_out_acc) begin
              w_state_next    = BUSY;
              w_load_out_skid = 1'b1;
            end
          end
          default: w_state_next = EMPTY;
        endcase
      end

      // Control state: reset empties the buffer and holds ready low for a cycle.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_state <= EMPTY;
          r_ready <= 1'b0;
        end else begin
          r_state <= w_state_next;
          r_ready <= (w_state_next != FULL);
        end
      end

      // Payload storage: no reset, contents are ignored while valid is low.
      always_ff @(posedge i_clk) begin
        if (w_load_out_in) begin
          r_out <= i_data;
        end else if (w_load_out_skid) begin
          r_out <= r_skid;
        end
        if (w_load_skid) begin
          r_skid <= i_data;
        end
      end

      assign o_valid = (r_state != EMPTY);
      assign o_ready = r_ready;
      assign o_data  = r_out;
    end else begin : g_wire
      assign o_valid = i_valid;
      assign o_ready = i_ready;
      assign o_data  = i_data;
    end
  endgenerate
endmodule

// File: rtl/rggen_axi4lite_register_slice.sv
// ---------------------------------------------------------------------------
// rggen_axi4lite_register_slice
// Per-channel AXI4-Lite pipeline slice in front of the bus adapter. Each of
// AW, W, AR (s->m) and B, R (m->s) is an independent skid buffer, or a wire
// when its CHANNEL_SLICE bit ({R,B,AR,W,AW}) is 0.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   s_axi4lite_if  : upstream side (interconnect master connects here)
//   m_axi4lite_if  : downstream side (adapter slave port connects here)
// ---------------------------------------------------------------------------
module rggen_axi4lite_register_slice
  import rggen_rtl_pkg::*;
#(
  parameter int         ADDRESS_WIDTH = 8,
  parameter int         BUS_WIDTH     = 32,
  parameter logic [4:0] CHANNEL_SLICE = 5'b11111
)(
  input  logic            i_clk,
  input  logic            i_rst,
  rggen_axi4lite_if.slave  s_axi4lite_if,
  rggen_axi4lite_if.master m_axi4lite_if
);
  localparam int AW_W = ADDRESS_WIDTH + RGGEN_AXI_PROT_W;
  localparam int W_W  = BUS_WIDTH + BUS_WIDTH / 8;
  localparam int AR_W = ADDRESS_WIDTH + RGGEN_AXI_PROT_W;
  localparam int B_W  = RGGEN_AXI_RESP_W;
  localparam int R_W  = BUS_WIDTH + RGGEN_AXI_RESP_W;

  logic [AW_W-1:0] w_aw_data;
  logic [W_W-1:0]  w_w_data;
  logic [AR_W-1:0] w_ar_data;
  logic [B_W-1:0]  w_b_data;
  logic [R_W-1:0]  w_r_data;

  rggen_skid_buffer #(.WIDTH(AW_W), .ENABLE(CHANNEL_SLICE[RGGEN_CH_AW])) u_aw (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(s_axi4lite_if.awvalid), .o_ready(s_axi4lite_if.awready),
    .i_data({s_axi4lite_if.awprot, s_axi4lite_if.awaddr}),
    .o_valid(m_axi4lite_if.awvalid), .i_ready(m_axi4lite_if.awready),
    .o_data(w_aw_data)
  );
  assign {m_axi4lite_if.awprot, m_axi4lite_if.awaddr} = w_aw_data;

  rggen_skid_buffer #(.WIDTH(W_W), .ENABLE(CHANNEL_SLICE[RGGEN_CH_W])) u_w (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(s_axi4lite_if.wvalid), .o_ready(s_axi4lite_if.wready),
    .i_data({s_axi4lite_if.wstrb, s_axi4lite_if.wdata}),
    .o_valid(m_axi4lite_if.wvalid), .i_ready(m_axi4lite_if.wready),
    .o_data(w_w_data)
  );
  assign {m_axi4lite_if.wstrb, m_axi4lite_if.wdata} = w_w_data;

  rggen_skid_buffer #(.WIDTH(AR_W), .ENABLE(CHANNEL_SLICE[RGGEN_CH_AR])) u_ar (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(s_axi4lite_if.arvalid), .o_ready(s_axi4lite_if.arready),
    .i_data({s_axi4lite_if.arprot, s_axi4lite_if.araddr}),
    .o_valid(m_axi4lite_if.arvalid), .i_ready(m_axi4lite_if.arready),
    .o_data(w_ar_data)
  );
  assign {m_axi4lite_if.arprot, m_axi4lite_if.araddr} = w_ar_data;

  // Response channels run in the opposite direction: m side feeds s side.
  rggen_skid_buffer #(.WIDTH(B_W), .ENABLE(CHANNEL_SLICE[RGGEN_CH_B])) u_b (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(m_axi4lite_if.bvalid), .o_ready(m_axi4lite_if.bready),
    .i_data(m_axi4lite_if.bresp),
    .o_valid(s_axi4lite_if.bvalid), .i_ready(s_axi4lite_if.bready),
    .o_data(w_b_data)
  );
  assign s_axi4lite_if.bresp = w_b_data;

  rggen_skid_buffer #(.WIDTH(R_W), .ENABLE(CHANNEL_SLICE[RGGEN_CH_R])) u_r (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(m_axi4lite_if.rvalid), .o_ready(m_axi4lite_if.rready),
    .i_data({m_axi4lite_if.rresp, m_axi4lite_if.rdata}),
    .o_valid(s_axi4lite_if.rvalid), .i_ready(s_axi4lite_if.rready),
    .o_data(w_r_data)
  );
  assign {s_axi4lite_if.rresp, s_axi4lite_if.rdata} = w_r_data;
endmodule

// File: tb/tb_rggen_axi4lite_register_slice.sv
// ---------------------------------------------------------------------------
// Bench for rggen_axi4lite_register_slice. Instance dut has every channel
// sliced and is compared against a two-entry FIFO-per-channel model; instance
// dut_pt has every channel as a wire and must mirror its inputs exactly.
// ---------------------------------------------------------------------------
module tb_rggen_axi4lite_register_slice;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rggen_axi4lite_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) s_if ();
  rggen_axi4lite_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) m_if ();
  rggen_axi4lite_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) s2_if ();
  rggen_axi4lite_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) m2_if ();

  rggen_axi4lite_register_slice #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .CHANNEL_SLICE(5'b11111)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .s_axi4lite_if(s_if.slave), .m_axi4lite_if(m_if.master)
  );

  rggen_axi4lite_register_slice #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .CHANNEL_SLICE(5'b00000)
  ) dut_pt (
    .i_clk(clk), .i_rst(rst),
    .s_axi4lite_if(s2_if.slave), .m_axi4lite_if(m2_if.master)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] q [5][$];   // beats accepted upstream, not yet delivered
  int          n_out [5];
  bit          rst_last = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rand_pt();
    logic [63:0] r1, r2;
    r1 = {$urandom, $urandom};
    r2 = {$urandom, $urandom};
    {s2_if.awvalid, s2_if.awaddr, s2_if.awprot, s2_if.wvalid, s2_if.wdata, s2_if.wstrb,
     s2_if.arvalid, s2_if.araddr, s2_if.arprot, s2_if.bready, s2_if.rready} = r1[62:0];
    {m2_if.awready, m2_if.wready, m2_if.arready, m2_if.bvalid, m2_if.bresp,
     m2_if.rvalid, m2_if.rdata, m2_if.rresp} = r2[40:0];
  endtask

  // One clock: check at the falling edge, update the model, step past rising edge.
  task automatic cycle();
    logic        iv [5];
    logic        ir [5];
    logic        ov [5];
    logic        orr [5];
    logic [63:0] id [5];
    logic [63:0] od [5];
    int          occ;
    @(negedge clk);
    iv[0] = s_if.awvalid; ir[0] = s_if.awready; id[0] = 64'({s_if.awprot, s_if.awaddr});
    ov[0] = m_if.awvalid; orr[0] = m_if.awready; od[0] = 64'({m_if.awprot, m_if.awaddr});
    iv[1] = s_if.wvalid;  ir[1] = s_if.wready;  id[1] = 64'({s_if.wstrb, s_if.wdata});
    ov[1] = m_if.wvalid;  orr[1] = m_if.wready; od[1] = 64'({m_if.wstrb, m_if.wdata});
    iv[2] = s_if.arvalid; ir[2] = s_if.arready; id[2] = 64'({s_if.arprot, s_if.araddr});
    ov[2] = m_if.arvalid; orr[2] = m_if.arready; od[2] = 64'({m_if.arprot, m_if.araddr});
    iv[3] = m_if.bvalid;  ir[3] = m_if.bready;  id[3] = 64'(m_if.bresp);
    ov[3] = s_if.bvalid;  orr[3] = s_if.bready; od[3] = 64'(s_if.bresp);
    iv[4] = m_if.rvalid;  ir[4] = m_if.rready;  id[4] = 64'({m_if.rresp, m_if.rdata});
    ov[4] = s_if.rvalid;  orr[4] = s_if.rready; od[4] = 64'({s_if.rresp, s_if.rdata});
    for (int c = 0; c < 5; c++) begin
      occ = q[c].size();
      chk($sformatf("ch%0d_out_valid", c), 64'(ov[c]), 64'(occ > 0));
      chk($sformatf("ch%0d_in_ready", c), 64'(ir[c]), 64'(!rst_last && occ < 2));
      if (ov[c] && occ > 0) chk($sformatf("ch%0d_payload", c), od[c], q[c][0]);
    end
    chk("pt_s2m", {1'b0, m2_if.awvalid, m2_if.awaddr, m2_if.awprot, m2_if.wvalid, m2_if.wdata,
                   m2_if.wstrb, m2_if.arvalid, m2_if.araddr, m2_if.arprot, m2_if.bready, m2_if.rready},
                  {1'b0, s2_if.awvalid, s2_if.awaddr, s2_if.awprot, s2_if.wvalid, s2_if.wdata,
                   s2_if.wstrb, s2_if.arvalid, s2_if.araddr, s2_if.arprot, s2_if.bready, s2_if.rready});
    chk("pt_m2s", 64'({s2_if.awready, s2_if.wready, s2_if.arready, s2_if.bvalid, s2_if.bresp,
                       s2_if.rvalid, s2_if.rdata, s2_if.rresp}),
                  64'({m2_if.awready, m2_if.wready, m2_if.arready, m2_if.bvalid, m2_if.bresp,
                       m2_if.rvalid, m2_if.rdata, m2_if.rresp}));
    for (int c = 0; c < 5; c++) begin
      if (rst) begin
        q[c].delete();
      end else begin
        if (ov[c] && orr[c] && q[c].size() > 0) begin
          void'(q[c].pop_front());
          n_out[c]++;
        end
        if (iv[c] && ir[c]) q[c].push_back(id[c]);
      end
    end
    @(posedge clk);
    rst_last = rst;
    #1;
    rand_pt();
  endtask

  // Random traffic that keeps each offered beat stable until it is taken.
  task automatic rand_drive();
    logic [63:0] r;
    r = {$urandom, $urandom};
    if (!(s_if.awvalid && !s_if.awready)) {s_if.awvalid, s_if.awprot, s_if.awaddr} = r[11:0];
    if (!(s_if.arvalid && !s_if.arready)) {s_if.arvalid, s_if.arprot, s_if.araddr} = r[23:12];
    if (!(m_if.bvalid && !m_if.bready)) {m_if.bvalid, m_if.bresp} = r[26:24];
    {m_if.awready, m_if.wready, m_if.arready, s_if.bready, s_if.rready} = r[31:27];
    r = {$urandom, $urandom};
    if (!(s_if.wvalid && !s_if.wready)) {s_if.wvalid, s_if.wstrb, s_if.wdata} = r[36:0];
    r = {$urandom, $urandom};
    if (!(m_if.rvalid && !m_if.rready)) {m_if.rvalid, m_if.rresp, m_if.rdata} = r[34:0];
  endtask

  initial begin : main
    logic [31:0] wtbl [3];
    int          sent;
    int          guard;
    int          base;
    logic        acc;
    wtbl[0] = 32'hA5A5A5A5; wtbl[1] = 32'h1; wtbl[2] = 32'h2;
    for (int c = 0; c < 5; c++) n_out[c] = 0;
    {s_if.awvalid, s_if.awaddr, s_if.awprot} = '0;
    {s_if.wvalid, s_if.wdata, s_if.wstrb} = '0;
    {s_if.arvalid, s_if.araddr, s_if.arprot} = '0;
    s_if.bready = 1'b1; s_if.rready = 1'b1;
    m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
    {m_if.bvalid, m_if.bresp} = '0;
    {m_if.rvalid, m_if.rdata, m_if.rresp} = '0;
    rand_pt();

    // Reset held for three edges with an upstream beat waiting.
    rst = 1'b1; s_if.awvalid = 1'b1; s_if.awaddr = 8'h04;
    @(posedge clk); #1; rand_pt();
    cycle();
    chk("rst_awready", 64'(s_if.awready), 64'd0);
    chk("rst_m_awvalid", 64'(m_if.awvalid), 64'd0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("awready_after_release", 64'(s_if.awready), 64'd1);
    cycle();
    s_if.awvalid = 1'b0;
    chk("first_beat_valid", 64'(m_if.awvalid), 64'd1);
    chk("first_beat_addr", 64'(m_if.awaddr), 64'h04);
    cycle();

    // Back-to-back writes with downstream always ready.
    for (int i = 0; i < 3; i++) begin
      s_if.awvalid = 1'b1; s_if.awaddr = 8'(8'h10 + 4 * i);
      s_if.wvalid = 1'b1; s_if.wdata = wtbl[i]; s_if.wstrb = 4'hF;
      cycle();
      chk($sformatf("b2b_awaddr%0d", i), 64'(m_if.awaddr), 64'(8'h10 + 4 * i));
      chk($sformatf("b2b_wdata%0d", i), 64'(m_if.wdata), 64'(wtbl[i]));
    end
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    cycle(); cycle();

    // Read-address backpressure: fill to FULL, then drain.
    m_if.arready = 1'b0;
    s_if.arvalid = 1'b1; s_if.araddr = 8'h20;
    cycle();
    s_if.araddr = 8'h24;
    cycle();
    s_if.arvalid = 1'b0;
    chk("ar_full_ready", 64'(s_if.arready), 64'd0);
    chk("ar_head", 64'(m_if.araddr), 64'h20);
    cycle();
    chk("ar_head_stalled", 64'(m_if.araddr), 64'h20);
    m_if.arready = 1'b1;
    cycle();
    chk("ar_second_valid", 64'(m_if.arvalid), 64'd1);
    chk("ar_second", 64'(m_if.araddr), 64'h24);
    m_if.arready = 1'b0;
    cycle();
    chk("ar_second_stable", 64'(m_if.araddr), 64'h24);
    m_if.arready = 1'b1;
    cycle();
    chk("ar_drained", 64'(m_if.arvalid), 64'd0);

    // Read response held while upstream is not ready.
    base = n_out[4];
    s_if.rready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'hDEADBEEF; m_if.rresp = 2'b10;
    cycle();
    m_if.rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("r_held_valid", 64'(s_if.rvalid), 64'd1);
      chk("r_held_payload", 64'({s_if.rresp, s_if.rdata}), {30'd0, 2'b10, 32'hDEADBEEF});
      cycle();
    end
    s_if.rready = 1'b1;
    cycle();
    chk("r_single_xfer_valid", 64'(s_if.rvalid), 64'd0);
    chk("r_single_xfer_count", 64'(n_out[4] - base), 64'd1);

    // Write responses streaming while bready toggles.
    base = n_out[3]; sent = 0; guard = 0;
    s_if.bready = 1'b0;
    while (sent < 16 && guard < 100) begin
      m_if.bvalid = 1'b1;
      m_if.bresp = (sent % 2 == 1) ? 2'b01 : 2'b00;
      s_if.bready = ~s_if.bready;
      acc = m_if.bready;
      cycle();
      if (acc) sent++;
      guard++;
    end
    m_if.bvalid = 1'b0; s_if.bready = 1'b1;
    cycle(); cycle(); cycle();
    chk("b_all_sent", 64'(sent), 64'd16);
    chk("b_delivered", 64'(n_out[3] - base), 64'd16);

    // Reset while the AW channel holds two beats.
    m_if.awready = 1'b0;
    s_if.awvalid = 1'b1; s_if.awaddr = 8'h30;
    cycle();
    s_if.awaddr = 8'h34;
    cycle();
    s_if.awvalid = 1'b0;
    chk("aw_full_ready", 64'(s_if.awready), 64'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("aw_flushed_valid", 64'(m_if.awvalid), 64'd0);
    chk("aw_flushed_ready", 64'(s_if.awready), 64'd0);
    cycle();
    chk("aw_ready_back", 64'(s_if.awready), 64'd1);
    s_if.awvalid = 1'b1; s_if.awaddr = 8'h40; m_if.awready = 1'b1;
    cycle();
    s_if.awvalid = 1'b0;
    chk("aw_fresh_valid", 64'(m_if.awvalid), 64'd1);
    chk("aw_fresh_addr", 64'(m_if.awaddr), 64'h40);
    cycle();

    // Random traffic on all channels at once.
    for (int i = 0; i < 400; i++) begin
      rand_drive();
      cycle();
    end
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.arvalid = 1'b0;
    m_if.bvalid = 1'b0; m_if.rvalid = 1'b0;
    m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
    s_if.bready = 1'b1; s_if.rready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    for (int c = 0; c < 5; c++) chk($sformatf("ch%0d_drained", c), 64'(q[c].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
